// File: rtl/operand_hazard_ctrl.sv
// Operand hazard control: load-use stall, EX/MEM forwarding select and shared HI/LO divider sequencing.
// Latency: stall/bubble/forwarding/div_start are combinational; a divide keeps the divider busy for DIV_CYCLES cycles.
// Backpressure: stall_id holds PC/IF/ID/ID and bubble_ex injects a NOP while a load-use or divider hazard is open.
module operand_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_read_en_1,
    input  logic        id_read_en_2,
    input  logic [4:0]  id_read_addr_1,
    input  logic [4:0]  id_read_addr_2,
    input  logic        id_is_div,
    input  logic        id_read_hilo,
    input  logic        ex_write_en,
    input  logic [4:0]  ex_write_addr,
    input  logic        ex_is_load,
    input  logic        mem_write_en,
    input  logic [4:0]  mem_write_addr,
    input  logic        flush,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic [1:0]  fwd_sel_1,
    output logic [1:0]  fwd_sel_2,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_done,
    output logic [15:0] stall_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] count;
    logic [5:0] count_nxt;

    logic m1_ex;
    logic m2_ex;
    logic m1_mem;
    logic m2_mem;
    logic load_hazard;
    logic div_hazard;

    // Register $0 is hardwired to zero, so it never creates a dependency.
    assign m1_ex  = id_read_en_1 & (id_read_addr_1 != 5'd0) & ex_write_en  & (id_read_addr_1 == ex_write_addr);
    assign m2_ex  = id_read_en_2 & (id_read_addr_2 != 5'd0) & ex_write_en  & (id_read_addr_2 == ex_write_addr);
    assign m1_mem = id_read_en_1 & (id_read_addr_1 != 5'd0) & mem_write_en & (id_read_addr_1 == mem_write_addr);
    assign m2_mem = id_read_en_2 & (id_read_addr_2 != 5'd0) & mem_write_en & (id_read_addr_2 == mem_write_addr);

    assign div_busy    = (state == DIV_RUN);
    assign load_hazard = id_valid & ex_write_en & ex_is_load & (m1_ex | m2_ex);
    assign div_hazard  = id_valid & div_busy & (id_is_div | id_read_hilo);
    assign stall_id    = (load_hazard | div_hazard) & ~flush;
    assign bubble_ex   = stall_id;

    // Forwarding mux selects: a load result is not available in EX, so only ALU results forward from EX.
    always_comb begin
        fwd_sel_1 = 2'd0;
        fwd_sel_2 = 2'd0;
        if (m1_ex & ~ex_is_load) begin
            fwd_sel_1 = 2'd1;
        end else if (m1_mem) begin
            fwd_sel_1 = 2'd2;
        end
        if (m2_ex & ~ex_is_load) begin
            fwd_sel_2 = 2'd1;
        end else if (m2_mem) begin
            fwd_sel_2 = 2'd2;
        end
    end

    // Divider sequencer: start only from IDLE when nothing stalls; flush aborts without a done pulse.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        div_start = 1'b0;
        div_done  = 1'b0;
        case (state)
            IDLE: begin
                if (rst & id_valid & id_is_div & ~stall_id & ~flush) begin
                    div_start = 1'b1;
                    state_nxt = DIV_RUN;
                    count_nxt = DIV_LOAD;
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                    count_nxt = 6'd0;
                end else if (count == 6'd0) begin
                    div_done  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count - 6'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = 6'd0;
            end
        endcase
    end

    // Divider state and down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= 6'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
        end else if (stall_id && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Bench for operand_hazard_ctrl: table vectors, hand sequences for divider timing/flush/reset, random traffic vs model.
// Latency: outputs compared on the falling edge; the model advances on each rising edge.
// Backpressure: stall behaviour is predicted by the model from hazard rules.
module tb_operand_hazard_ctrl;

    localparam int DC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_read_en_1, id_read_en_2;
    logic [4:0]  id_read_addr_1, id_read_addr_2;
    logic        id_is_div, id_read_hilo;
    logic        ex_write_en, ex_is_load;
    logic [4:0]  ex_write_addr;
    logic        mem_write_en;
    logic [4:0]  mem_write_addr;
    logic        flush;
    logic        stall_id, bubble_ex, div_start, div_busy, div_done;
    logic [1:0]  fwd_sel_1, fwd_sel_2;
    logic [15:0] stall_count;

    operand_hazard_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
        .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
        .id_is_div(id_is_div), .id_read_hilo(id_read_hilo),
        .ex_write_en(ex_write_en), .ex_write_addr(ex_write_addr), .ex_is_load(ex_is_load),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .flush(flush),
        .stall_id(stall_id), .bubble_ex(bubble_ex), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
        .div_start(div_start), .div_busy(div_busy), .div_done(div_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: busy cycles remaining for the divider, and stalled cycles seen.
    int rem = 0;
    int sc  = 0;
    bit e_stall, e_start, e_busy, e_done;
    int e_f1, e_f2;

    typedef struct {
        logic       v, e1, e2;
        logic [4:0] a1, a2;
        logic       xwe;
        logic [4:0] xwa;
        logic       xld, mwe;
        logic [4:0] mwa;
        logic       fl;
        logic       es;
        logic [1:0] ef1, ef2;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fsel(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 0;
        if (ex_write_en && a == ex_write_addr && !ex_is_load) return 1;
        if (mem_write_en && a == mem_write_addr) return 2;
        return 0;
    endfunction

    task automatic model_eval();
        bit lh, dh;
        lh = id_valid && ex_write_en && ex_is_load &&
             ((id_read_en_1 && id_read_addr_1 != 0 && id_read_addr_1 == ex_write_addr) ||
              (id_read_en_2 && id_read_addr_2 != 0 && id_read_addr_2 == ex_write_addr));
        e_busy  = (rem > 0);
        dh      = id_valid && e_busy && (id_is_div || id_read_hilo);
        e_stall = (lh || dh) && !flush;
        e_start = rst && !e_busy && id_valid && id_is_div && !e_stall && !flush;
        e_done  = e_busy && (rem == 1) && !flush;
        e_f1    = fsel(id_read_en_1, id_read_addr_1);
        e_f2    = fsel(id_read_en_2, id_read_addr_2);
    endtask

    task automatic settle(input bit cmp);
        @(negedge clk);
        model_eval();
        if (cmp) begin
            chk("stall_id", stall_id, e_stall);
            chk("bubble_ex", bubble_ex, e_stall);
            chk("fwd_sel_1", fwd_sel_1, e_f1);
            chk("fwd_sel_2", fwd_sel_2, e_f2);
            chk("div_start", div_start, e_start);
            chk("div_busy", div_busy, e_busy);
            chk("div_done", div_done, e_done);
            chk("stall_count", stall_count, sc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_eval();
        if (rst) begin
            if (e_start) rem = DC;
            else if (rem > 0) rem = flush ? 0 : rem - 1;
            if (e_stall && sc < 65535) sc++;
        end
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_read_en_1 = 0; id_read_en_2 = 0;
        id_read_addr_1 = 0; id_read_addr_2 = 0;
        id_is_div = 0; id_read_hilo = 0;
        ex_write_en = 0; ex_write_addr = 0; ex_is_load = 0;
        mem_write_en = 0; mem_write_addr = 0; flush = 0;
    endtask

    task automatic issue_div();
        clear_in();
        id_valid = 1; id_is_div = 1;
        settle(1);
        chk("issue_start", div_start, 1);
        tick();
        clear_in();
    endtask

    initial begin
        bit saw_done;

        // Reset state, with inputs that would otherwise start a divide and raise a load hazard.
        clear_in();
        rst = 0;
        id_valid = 1; id_is_div = 1;
        id_read_en_1 = 1; id_read_addr_1 = 5'd5;
        ex_write_en = 1; ex_write_addr = 5'd5; ex_is_load = 1;
        #2;
        chk("rst_div_start", div_start, 0);
        chk("rst_div_busy", div_busy, 0);
        chk("rst_div_done", div_done, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_stall_follows", stall_id, 1);
        tick();
        chk("rst_held_count", stall_count, 0);
        rst = 1;
        clear_in();

        // Table-driven combinational vectors with the divider idle.
        vecs[0] = '{0,0,0, 5'd0,5'd0, 0,5'd0, 0,0,5'd0, 0, 0,2'd0,2'd0};
        vecs[1] = '{1,1,0, 5'd5,5'd0, 1,5'd5, 1,0,5'd0, 0, 1,2'd0,2'd0};
        vecs[2] = '{1,0,1, 5'd0,5'd5, 1,5'd5, 1,0,5'd0, 0, 1,2'd0,2'd0};
        vecs[3] = '{1,1,0, 5'd5,5'd0, 1,5'd5, 1,0,5'd0, 1, 0,2'd0,2'd0};
        vecs[4] = '{0,1,0, 5'd5,5'd0, 1,5'd5, 1,0,5'd0, 0, 0,2'd0,2'd0};
        vecs[5] = '{1,1,1, 5'd7,5'd7, 1,5'd7, 0,1,5'd7, 0, 0,2'd1,2'd1};
        vecs[6] = '{1,1,1, 5'd9,5'd4, 0,5'd0, 0,1,5'd9, 0, 0,2'd2,2'd0};
        vecs[7] = '{1,0,0, 5'd9,5'd0, 0,5'd0, 0,1,5'd9, 0, 0,2'd0,2'd0};
        vecs[8] = '{1,1,0, 5'd0,5'd0, 1,5'd0, 1,0,5'd0, 0, 0,2'd0,2'd0};
        vecs[9] = '{1,0,1, 5'd0,5'd6, 0,5'd6, 0,1,5'd6, 0, 0,2'd0,2'd2};
        for (int i = 0; i < 10; i++) begin
            clear_in();
            id_valid = vecs[i].v; id_read_en_1 = vecs[i].e1; id_read_en_2 = vecs[i].e2;
            id_read_addr_1 = vecs[i].a1; id_read_addr_2 = vecs[i].a2;
            ex_write_en = vecs[i].xwe; ex_write_addr = vecs[i].xwa; ex_is_load = vecs[i].xld;
            mem_write_en = vecs[i].mwe; mem_write_addr = vecs[i].mwa; flush = vecs[i].fl;
            settle(1);
            chk($sformatf("vec%0d_stall", i), stall_id, vecs[i].es);
            chk($sformatf("vec%0d_fwd1", i), fwd_sel_1, vecs[i].ef1);
            chk($sformatf("vec%0d_fwd2", i), fwd_sel_2, vecs[i].ef2);
            tick();
        end

        // Load-use: one stall, then the load result is forwarded from MEM.
        clear_in();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 5'd5;
        ex_write_en = 1; ex_write_addr = 5'd5; ex_is_load = 1;
        settle(1);
        chk("lu_stall", stall_id, 1);
        chk("lu_bubble", bubble_ex, 1);
        tick();
        ex_write_en = 0; ex_is_load = 0;
        mem_write_en = 1; mem_write_addr = 5'd5;
        settle(1);
        chk("lu_stall_after", stall_id, 0);
        chk("lu_fwd_mem", fwd_sel_1, 2);
        tick();

        // EX over MEM priority, then $0 never forwards or stalls.
        clear_in();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 5'd3; id_read_en_2 = 1; id_read_addr_2 = 5'd3;
        ex_write_en = 1; ex_write_addr = 5'd3; mem_write_en = 1; mem_write_addr = 5'd3;
        settle(1);
        chk("fwd_ex_prio_1", fwd_sel_1, 1);
        chk("fwd_ex_prio_2", fwd_sel_2, 1);
        tick();
        id_read_addr_1 = 0; id_read_addr_2 = 0; ex_write_addr = 0; mem_write_addr = 0; ex_is_load = 1;
        settle(1);
        chk("r0_fwd", fwd_sel_1, 0);
        chk("r0_stall", stall_id, 0);
        tick();

        // Divide timing with MFLO waiting in ID.
        issue_div();
        id_valid = 1; id_read_hilo = 1;
        for (int k = 1; k <= DC; k++) begin
            settle(1);
            chk("dt_busy", div_busy, 1);
            chk("dt_mflo_stall", stall_id, 1);
            chk("dt_done", div_done, (k == DC));
            tick();
        end
        settle(1);
        chk("dt_busy_end", div_busy, 0);
        chk("dt_mflo_go", stall_id, 0);
        tick();

        // Second divide arriving in the done cycle stalls, then starts.
        issue_div();
        for (int k = 1; k < DC; k++) begin settle(1); tick(); end
        id_valid = 1; id_is_div = 1;
        settle(1);
        chk("d2_done", div_done, 1);
        chk("d2_stall", stall_id, 1);
        chk("d2_nostart", div_start, 0);
        tick();
        settle(1);
        chk("d2_start", div_start, 1);
        tick();
        clear_in();
        for (int k = 1; k <= DC; k++) begin settle(1); tick(); end

        // Flush ten cycles into a divide aborts it with no done pulse.
        issue_div();
        for (int k = 1; k < 10; k++) begin settle(1); tick(); end
        flush = 1;
        settle(1);
        chk("fa_done", div_done, 0);
        tick();
        flush = 0;
        settle(1);
        chk("fa_busy_after", div_busy, 0);
        tick();

        // Flush in the final divide cycle suppresses done.
        issue_div();
        for (int k = 1; k < DC; k++) begin settle(1); tick(); end
        flush = 1;
        settle(1);
        chk("fl_last_done", div_done, 0);
        tick();
        flush = 0;
        settle(1);
        chk("fl_last_busy", div_busy, 0);
        tick();

        // Flush beats a divide start.
        id_valid = 1; id_is_div = 1; flush = 1;
        settle(1);
        chk("fs_nostart", div_start, 0);
        tick();
        clear_in();
        settle(1);
        chk("fs_idle", div_busy, 0);
        tick();

        // Load hazard blocks a divide start until it clears.
        id_valid = 1; id_is_div = 1; id_read_en_1 = 1; id_read_addr_1 = 5'd8;
        ex_write_en = 1; ex_write_addr = 5'd8; ex_is_load = 1;
        settle(1);
        chk("lh_div_stall", stall_id, 1);
        chk("lh_div_nostart", div_start, 0);
        tick();
        ex_write_en = 0; ex_is_load = 0;
        settle(1);
        chk("lh_div_start", div_start, 1);
        tick();
        clear_in();
        for (int k = 1; k <= DC; k++) begin settle(1); tick(); end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            id_valid       = ($urandom_range(0, 3) != 0);
            id_read_en_1   = $urandom_range(0, 1);
            id_read_en_2   = $urandom_range(0, 1);
            id_read_addr_1 = 5'($urandom_range(0, 3));
            id_read_addr_2 = 5'($urandom_range(0, 3));
            id_is_div      = ($urandom_range(0, 7) == 0);
            id_read_hilo   = ($urandom_range(0, 3) == 0);
            ex_write_en    = $urandom_range(0, 1);
            ex_write_addr  = 5'($urandom_range(0, 3));
            ex_is_load     = $urandom_range(0, 1);
            mem_write_en   = $urandom_range(0, 1);
            mem_write_addr = 5'($urandom_range(0, 3));
            flush          = ($urandom_range(0, 39) == 0);
            settle(1);
            tick();
        end
        clear_in();
        for (int k = 0; k <= DC; k++) begin settle(1); tick(); end

        // Hold a load hazard long enough to saturate the stall counter.
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 5'd2;
        ex_write_en = 1; ex_write_addr = 5'd2; ex_is_load = 1;
        for (int k = 0; k < 70000; k++) begin settle(0); tick(); end
        settle(1);
        chk("sat_count", stall_count, 16'hFFFF);
        tick();

        // Reset asserted mid-divide clears everything at once and no done follows.
        issue_div();
        for (int k = 1; k < 5; k++) begin settle(1); tick(); end
        id_valid = 1; id_is_div = 1;
        #1;
        rst = 0;
        rem = 0; sc = 0;
        #1;
        chk("mr_busy", div_busy, 0);
        chk("mr_done", div_done, 0);
        chk("mr_start", div_start, 0);
        chk("mr_count", stall_count, 0);
        settle(1);
        tick();
        rst = 1;
        clear_in();
        saw_done = 0;
        for (int k = 0; k < DC + 8; k++) begin
            settle(1);
            if (div_done) saw_done = 1;
            tick();
        end
        chk("mr_no_done", saw_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
